// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM encoding and sync-character constants.
package uart_pkg;

    typedef enum logic [2:0] {
        AB_IDLE      = 3'd0,
        AB_WAIT_HIGH = 3'd1,
        AB_WAIT_FALL = 3'd2,
        AB_MEASURE   = 3'd3,
        AB_DONE      = 3'd4,
        AB_ERR       = 3'd5
    } ab_state_t;

    // 0x55 framed as 8N1 gives 9 alternating edges bounding 8 equal intervals
    localparam int SYNC_EDGES     = 9;
    localparam int SYNC_INTERVALS = 8;
    localparam int SYNC_SHIFT     = 3;
    localparam int TOL_SHIFT      = 2;

endpackage

// File: rtl/synchronizer.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
module synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift chain; the first stage may go metastable, later stages settle it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_autobaud.sv
// Baud-rate detector: times a 0x55 sync character on rx and reports
// the rounded clock-cycles-per-bit divisor for the baud divider.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] MIN_DIV     = CNT_W'(32'd4),
    parameter logic [CNT_W-1:0] MAX_DIV     = CNT_W'(32'h0010_0000),
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(32'h2)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rx_in,
    input  logic             start_in,
    output logic [CNT_W-1:0] div_out,
    output logic             div_valid_out,
    output logic             busy_out,
    output logic             err_out
);

    localparam int TOT_W = CNT_W + SYNC_SHIFT;

    logic             w_sync;
    logic             r_prev;
    logic             w_edge;
    logic             w_fall;
    ab_state_t        r_state;
    ab_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [TOT_W-1:0] r_total;
    logic [TOT_W-1:0] w_round;
    logic [CNT_W-1:0] r_t1;
    logic [3:0]       r_edges;
    logic [CNT_W-1:0] r_div;
    logic             r_valid;
    logic             r_busy;
    logic             r_err;
    logic             w_bad;
    logic             w_last;
    logic             w_clr_acc;
    logic             w_take;
    logic             w_busy_next;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    synchronizer #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk_in),
        .rst_n (1'b1),
        .d     (rx_in),
        .q     (w_sync)
    );

    // Previous synced sample for edge detection; idle-high after reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign w_edge  = w_sync ^ r_prev;
    assign w_fall  = r_prev & ~w_sync;
    assign w_last  = (r_edges == 4'(SYNC_INTERVALS - 1));
    assign w_round = r_total + (TOT_W'(32'd1) << (SYNC_SHIFT - 1));

    // Interval check: T1 against the glitch floor, later ones against T1 +/-25%
    always_comb begin
        w_bad = 1'b0;
        if (r_edges == 4'd0) begin
            w_bad = (r_cnt < MIN_DIV);
        end else begin
            w_bad = (abs_diff(r_cnt, r_t1) > (r_t1 >> TOL_SHIFT));
        end
    end

    // Next-state logic; start_in re-arms from any state
    always_comb begin
        w_next    = r_state;
        w_clr_acc = 1'b0;
        w_take    = 1'b0;
        case (r_state)
            AB_IDLE: begin
                w_next = AB_IDLE;
            end
            AB_WAIT_HIGH: begin
                if (w_sync) begin
                    w_next = AB_WAIT_FALL;
                end else begin
                    w_next = AB_WAIT_HIGH;
                end
            end
            AB_WAIT_FALL: begin
                if (w_fall) begin
                    w_next    = AB_MEASURE;
                    w_clr_acc = 1'b1;
                end else begin
                    w_next = AB_WAIT_FALL;
                end
            end
            AB_MEASURE: begin
                if (w_edge) begin
                    if (w_bad) begin
                        w_next = AB_ERR;
                    end else begin
                        w_take = 1'b1;
                        w_next = w_last ? AB_DONE : AB_MEASURE;
                    end
                end else if (r_cnt >= MAX_DIV) begin
                    w_next = AB_ERR;
                end else begin
                    w_next = AB_MEASURE;
                end
            end
            AB_DONE: begin
                w_next = AB_IDLE;
            end
            AB_ERR: begin
                w_next = AB_IDLE;
            end
            default: begin
                w_next = AB_IDLE;
            end
        endcase
        if (start_in) begin
            w_next = AB_WAIT_HIGH;
        end else begin
            w_next = w_next;
        end
        w_busy_next = (w_next == AB_WAIT_HIGH) || (w_next == AB_WAIT_FALL) ||
                      (w_next == AB_MEASURE);
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= AB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Interval counter and accumulator; the counter restarts at 1 so that
    // its value on an edge equals the full edge-to-edge cycle count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt   <= CNT_W'(32'd0);
            r_total <= TOT_W'(32'd0);
            r_t1    <= CNT_W'(32'd0);
            r_edges <= 4'd0;
        end else if (w_clr_acc) begin
            r_cnt   <= CNT_W'(32'd1);
            r_total <= TOT_W'(32'd0);
            r_edges <= 4'd0;
        end else if (w_take) begin
            r_cnt   <= CNT_W'(32'd1);
            r_total <= r_total + TOT_W'(r_cnt);
            r_edges <= r_edges + 4'd1;
            if (r_edges == 4'd0) begin
                r_t1 <= r_cnt;
            end
        end else if (r_state == AB_MEASURE) begin
            r_cnt <= r_cnt + CNT_W'(32'd1);
        end
    end

    // Registered result/status outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div   <= DEFAULT_DIV;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (start_in) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end else if (r_state == AB_DONE) begin
                r_div   <= CNT_W'(w_round >> SYNC_SHIFT);
                r_valid <= 1'b1;
            end else if (r_state == AB_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign div_out       = r_div;
    assign div_valid_out = r_valid;
    assign busy_out      = r_busy;
    assign err_out       = r_err;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed self-checking bench for uart_autobaud.
module tb_uart_autobaud;

    localparam logic [31:0] TB_MAX = 32'd1000;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        start;
    logic [31:0] div;
    logic        valid;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int durs[8];
    int lat;

    uart_autobaud #(
        .CNT_W       (32),
        .MIN_DIV     (32'd4),
        .MAX_DIV     (TB_MAX),
        .DEFAULT_DIV (32'h2)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rx_in         (rx),
        .start_in      (start),
        .div_out       (div),
        .div_valid_out (valid),
        .busy_out      (busy),
        .err_out       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives the 8 levels bounding T1..T8, then the 9th edge (fall into d7),
    // counts cycles until div_valid, then finishes d7 and the stop bit.
    task automatic send_sync(output int n);
        for (int i = 0; i < 8; i++) begin
            rx = (i % 2 == 1) ? 1'b1 : 1'b0;
            repeat (durs[i]) tick();
        end
        rx = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        repeat (16) tick();
        rx = 1'b1;
        repeat (20) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int bl);
        rx = 1'b0;
        repeat (bl) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bl) tick();
        end
        rx = 1'b1;
        repeat (bl) tick();
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        chk("rst_div", div, 32'd2);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick();

        // 0x55 at 16 clk/bit, with latency from 9th edge to div_valid
        arm();
        chk("arm_busy", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        durs = '{16, 16, 16, 16, 16, 16, 16, 16};
        send_sync(lat);
        chk("u16_latency", lat, 32'd4);
        chk("u16_div", div, 32'd16);
        chk("u16_valid", {31'd0, valid}, 32'd1);
        chk("u16_err", {31'd0, err}, 32'd0);
        chk("u16_busy", {31'd0, busy}, 32'd0);

        // Alternating 15/17 around T1 = 16: total 128
        arm();
        chk("rearm_valid_clr", {31'd0, valid}, 32'd0);
        repeat (3) tick();
        durs = '{16, 17, 15, 17, 15, 17, 15, 16};
        send_sync(lat);
        chk("alt_div", div, 32'd16);
        chk("alt_valid", {31'd0, valid}, 32'd1);
        chk("alt_err", {31'd0, err}, 32'd0);

        // 0x0D: T4 = 32 vs T1 = 16 is outside tolerance
        arm();
        repeat (3) tick();
        send_byte(8'h0D, 16);
        repeat (10) tick();
        chk("x0d_err", {31'd0, err}, 32'd1);
        chk("x0d_valid", {31'd0, valid}, 32'd0);
        chk("x0d_div_held", div, 32'd16);
        chk("x0d_busy", {31'd0, busy}, 32'd0);

        // 434 clk/bit (50 MHz / 115200)
        arm();
        repeat (3) tick();
        durs = '{434, 434, 434, 434, 434, 434, 434, 434};
        send_sync(lat);
        chk("b434_div", div, 32'd434);
        chk("b434_valid", {31'd0, valid}, 32'd1);
        chk("b434_err", {31'd0, err}, 32'd0);

        // 2-cycle glitch is shorter than MIN_DIV
        arm();
        repeat (3) tick();
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (10) tick();
        chk("glitch_err", {31'd0, err}, 32'd1);
        chk("glitch_valid", {31'd0, valid}, 32'd0);
        chk("glitch_div_held", div, 32'd434);
        arm();
        chk("rearm_err_clr", {31'd0, err}, 32'd0);
        repeat (3) tick();
        durs = '{20, 20, 20, 20, 20, 20, 20, 20};
        send_sync(lat);
        chk("after_glitch_div", div, 32'd20);
        chk("after_glitch_valid", {31'd0, valid}, 32'd1);
        chk("after_glitch_err", {31'd0, err}, 32'd0);

        // Start bit then stuck low: error MAX_DIV + 4 cycles after the fall
        arm();
        repeat (3) tick();
        rx = 1'b0;
        lat = 0;
        while (err !== 1'b1 && lat < 1200) begin
            tick();
            lat++;
            if (lat == 500) begin
                chk("to_busy_mid", {31'd0, busy}, 32'd1);
            end
        end
        chk("to_latency", lat, TB_MAX + 32'd4);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_div_held", div, 32'd20);
        rx = 1'b1;
        repeat (10) tick();

        // Reset after 4 edges
        arm();
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 1) ? 1'b1 : 1'b0;
            repeat (16) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_div", div, 32'd2);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        rx = 1'b1;
        repeat (10) tick();

        // start_in mid-MEASURE restarts; next 0x55 at 24 clk/bit
        arm();
        repeat (3) tick();
        rx = 1'b0;
        repeat (16) tick();
        rx = 1'b1;
        repeat (16) tick();
        rx = 1'b0;
        repeat (8) tick();
        arm();
        chk("restart_busy", {31'd0, busy}, 32'd1);
        repeat (8) tick();
        rx = 1'b1;
        repeat (30) tick();
        chk("restart_no_result", {31'd0, valid}, 32'd0);
        durs = '{24, 24, 24, 24, 24, 24, 24, 24};
        send_sync(lat);
        chk("restart_div", div, 32'd24);
        chk("restart_valid", {31'd0, valid}, 32'd1);
        chk("restart_err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
